isolation_tree_scorer: RTL and testbench

Parametrised isolation-tree evaluator: walks one configurable binary split tree per sample, one level per clock, and reports the path length plus an anomaly flag (short path = anomalous). It replaces the single-pattern anomaly state machine in the anomaly-detection datapath. It sits between the byte/feature assembler upstream and the result/score aggregator downstream. Uses valid/ready handshakes on both sides and a register-write configuration port.

---
 rtl/isolation_tree_pkg.sv | 36 +++
 rtl/itree_node_table.sv | 35 +++
 rtl/isolation_tree_scorer.sv | 157 +++++++++++++++
 tb/tb_isolation_tree_scorer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/isolation_tree_pkg.sv
// isolation_tree_pkg
//   Shared definitions for the isolation-tree scorer: FSM state encoding,
//   configuration word layout helpers and heap-order node-index helpers.
//   Config word layout (MSB..LSB): {leaf, feat_idx[FIDX_W-1:0], split[DATA_W-1:0]}.
package isolation_tree_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    // Feature-index width; a single-feature sample still gets a 1-bit field.
    function automatic int fidx_width(input int num_feat);
        return (num_feat > 1) ? $clog2(num_feat) : 1;
    endfunction

    // Config word field positions.
    function automatic int cfg_feat_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int cfg_leaf_bit(input int data_w, input int fidx_w);
        return data_w + fidx_w;
    endfunction

    function automatic int cfg_width(input int data_w, input int fidx_w);
        return 1 + fidx_w + data_w;
    endfunction

    // Heap order: left child 2i+1 (feature < split), right child 2i+2.
    function automatic int unsigned child_of(input int unsigned node, input logic go_right);
        return 2 * node + 1 + (go_right ? 1 : 0);
    endfunction

endpackage

// File: rtl/itree_node_table.sv
// itree_node_table
//   NODES-entry register file holding the split tree in heap order.
//   One synchronous write port, one asynchronous read port, cleared by reset.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (clears all entries)
//   we/waddr/wdata write strobe, node index, entry data
//   raddr/rdata    combinational read of entry raddr (out-of-range reads 0)
module itree_node_table #(
    parameter int DEPTH   = 3,
    parameter int ENTRY_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [DEPTH-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [DEPTH-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    localparam int NODES = (1 << DEPTH) - 1;

    logic [ENTRY_W-1:0] mem [NODES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NODES; i++) mem[i] <= '0;
        end else if (we && (waddr < DEPTH'(NODES))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < DEPTH'(NODES)) ? mem[raddr] : '0;

endmodule

// File: rtl/isolation_tree_scorer.sv
// isolation_tree_scorer
//   Walks one configurable binary split tree per sample, one level per clock,
//   and reports the number of splits taken plus an anomaly flag
//   (path_len <= anom_thresh). Short paths mean the sample is easy to isolate.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   in_data/in_valid/in_ready sample input handshake (ready only in IDLE)
//   out_valid/out_ready      result handshake; anomaly, path_len held while valid
//   cfg_we/cfg_addr/cfg_data node table / threshold write port
//                            (addr all-ones = anom_thresh)
//   cfg_err                  one-cycle pulse when a config write was dropped
//   sample_count             results delivered, wrapping
module isolation_tree_scorer
    import isolation_tree_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_FEAT = 4,
    parameter  int DEPTH    = 3,
    parameter  int CNT_W    = 16,
    localparam int FIDX_W   = fidx_width(NUM_FEAT),
    localparam int LEN_W    = $clog2(DEPTH + 1),
    localparam int CFG_W    = cfg_width(DATA_W, FIDX_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_FEAT*DATA_W-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       anomaly,
    output logic [LEN_W-1:0]           path_len,
    input  logic                       cfg_we,
    input  logic [DEPTH-1:0]           cfg_addr,
    input  logic [CFG_W-1:0]           cfg_data,
    output logic                       cfg_err,
    output logic [CNT_W-1:0]           sample_count
);

    localparam int NODES    = (1 << DEPTH) - 1;
    localparam int FEAT_LSB = cfg_feat_lsb(DATA_W);
    localparam int LEAF_BIT = cfg_leaf_bit(DATA_W, FIDX_W);

    state_t                           state;
    logic [NUM_FEAT-1:0][DATA_W-1:0]  sample_q;
    logic [DEPTH-1:0]                 node_q;
    logic [LEN_W-1:0]                 len_q;
    logic [LEN_W-1:0]                 thresh_q;

    logic [CFG_W-1:0]  node_ent;
    logic [DATA_W-1:0] node_split;
    logic [FIDX_W-1:0] node_feat;
    logic              node_leaf;
    logic [DATA_W-1:0] feat_val;
    logic              go_right;
    logic [LEN_W-1:0]  len_next;
    logic [DEPTH-1:0]  child_idx;

    // Config writes only land while idle and not racing a sample accept,
    // so a walk always sees a consistent table.
    logic cfg_ok, tbl_we, thr_we;
    assign cfg_ok = cfg_we && (state == IDLE) && !in_valid;
    assign tbl_we = cfg_ok && (cfg_addr != DEPTH'(NODES));
    assign thr_we = cfg_ok && (cfg_addr == DEPTH'(NODES));

    itree_node_table #(
        .DEPTH   (DEPTH),
        .ENTRY_W (CFG_W)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (node_q),
        .rdata (node_ent)
    );

    assign node_split = node_ent[DATA_W-1:0];
    assign node_feat  = node_ent[FEAT_LSB +: FIDX_W];
    assign node_leaf  = node_ent[LEAF_BIT];

    // Indices with no matching feature (non-power-of-two NUM_FEAT) fall back to feature 0.
    always_comb begin
        feat_val = sample_q[0];
        for (int f = 0; f < NUM_FEAT; f++) begin
            if (node_feat == FIDX_W'(f)) feat_val = sample_q[f];
        end
    end

    assign go_right  = (feat_val >= node_split);
    assign len_next  = len_q + LEN_W'(1);
    // Child index is truncated; when it overflows the walk ends on depth anyway.
    assign child_idx = DEPTH'(child_of(int'(node_q), go_right));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sample_q     <= '0;
            node_q       <= '0;
            len_q        <= '0;
            thresh_q     <= LEN_W'(1);
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            anomaly      <= 1'b0;
            path_len     <= '0;
            cfg_err      <= 1'b0;
            sample_count <= '0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (thr_we) thresh_q <= cfg_data[LEN_W-1:0];

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample_q <= in_data;
                        node_q   <= '0;
                        len_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= WALK;
                    end
                end
                WALK: begin
                    if (node_leaf) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        path_len  <= len_q;
                        anomaly   <= (len_q <= thresh_q);
                    end else begin
                        node_q <= child_idx;
                        len_q  <= len_next;
                        if (len_next == LEN_W'(DEPTH)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            path_len  <= len_next;
                            anomaly   <= (len_next <= thresh_q);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sample_count <= sample_count + CNT_W'(1);
                        out_valid    <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isolation_tree_scorer.sv
// tb_isolation_tree_scorer
//   Directed bench for isolation_tree_scorer (DATA_W=8, NUM_FEAT=4, DEPTH=3,
//   CNT_W=4 so the delivery counter wrap is reachable). Expected results are
//   queued when a sample is driven and popped when out_valid appears.
module tb_isolation_tree_scorer;

    localparam int DATA_W   = 8;
    localparam int NUM_FEAT = 4;
    localparam int DEPTH    = 3;
    localparam int CNT_W    = 4;
    localparam int LEN_W    = 2;
    localparam int CFG_W    = 11;

    // Config words {leaf, feat_idx[1:0], split[7:0]}
    localparam logic [CFG_W-1:0] ROOT_F1_80 = 11'h180;
    localparam logic [CFG_W-1:0] LEAF       = 11'h400;

    typedef struct {
        int len;
        bit anom;
        int lat;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic [NUM_FEAT*DATA_W-1:0] in_data = '0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic                       anomaly;
    logic [LEN_W-1:0]           path_len;
    logic                       cfg_we = 1'b0;
    logic [DEPTH-1:0]           cfg_addr = '0;
    logic [CFG_W-1:0]           cfg_data = '0;
    logic                       cfg_err;
    logic [CNT_W-1:0]           sample_count;

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    isolation_tree_scorer #(
        .DATA_W   (DATA_W),
        .NUM_FEAT (NUM_FEAT),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .anomaly      (anomaly),
        .path_len     (path_len),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_err      (cfg_err),
        .sample_count (sample_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [DEPTH-1:0] addr, input logic [CFG_W-1:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("cfg_err_on_idle_write", cfg_err, 1'b0);
    endtask

    // Offer one sample, measure latency from the accept cycle, compare against
    // the queued expectation, optionally stall the result for `hold` cycles,
    // then complete the output handshake.
    task automatic run(input logic [31:0] data, input int exp_len, input bit exp_anom,
                       input int exp_lat, input int hold, input bit walk_cfg);
        exp_t e;
        int   n;
        sb_q.push_back('{len: exp_len, anom: exp_anom, lat: exp_lat});
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1'b1);
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        if (walk_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = '0;
            cfg_data = LEAF;
        end
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (walk_cfg && n == 2) begin
                check("cfg_err_pulse_in_walk", cfg_err, 1'b1);
                cfg_we = 1'b0;
            end
        end
        check("out_valid_within_bound", out_valid, 1'b1);
        e = sb_q.pop_front();
        check("path_len", path_len, e.len);
        check("anomaly", anomaly, e.anom);
        check("latency", n, e.lat);
        if (hold > 0) begin
            in_data  = 32'hFFFF_FFFF;
            in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_path_len", path_len, e.len);
                check("hold_anomaly", anomaly, e.anom);
                check("hold_in_ready", in_ready, 1'b0);
                check("hold_count", sample_count, exp_cnt);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        check("out_valid_after_accept", out_valid, 1'b0);
        check("in_ready_after_accept", in_ready, 1'b1);
        check("sample_count", sample_count, exp_cnt);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_anomaly", anomaly, 1'b0);
        check("rst_path_len", path_len, 0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_count", sample_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // Default table: walks right to full depth, threshold 1 -> not anomalous
        run(32'h0, 3, 1'b0, 4, 0, 1'b0);

        // Root splits on feature 1 at 0x80, node 1 is a leaf
        cfg_write(3'd0, ROOT_F1_80);
        cfg_write(3'd1, LEAF);
        run(32'h0000_1000, 1, 1'b1, 3, 0, 1'b0);
        run(32'h0000_7F00, 1, 1'b1, 3, 0, 1'b0);   // just below split
        run(32'h0000_8000, 3, 1'b0, 4, 0, 1'b0);   // equal to split goes right

        // Config write during WALK is dropped; table unchanged afterwards
        run(32'h0000_8000, 3, 1'b0, 4, 0, 1'b1);
        check("cfg_err_clears", cfg_err, 1'b0);
        run(32'h0000_8000, 3, 1'b0, 4, 0, 1'b0);

        // Threshold 3 flags full-depth samples
        cfg_write(3'd7, 11'd3);
        run(32'h0000_8000, 3, 1'b1, 4, 0, 1'b0);

        // Backpressure for 5 cycles
        run(32'h0000_1000, 1, 1'b1, 3, 5, 1'b0);

        // Root leaf: minimum latency
        cfg_write(3'd0, LEAF);
        run(32'h0000_0000, 0, 1'b1, 2, 0, 1'b0);

        // Reset mid-WALK
        @(negedge clk);
        in_data  = 32'h0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("walk_before_reset", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_count", sample_count, 0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        // Table and threshold back to defaults
        run(32'h0000_0000, 3, 1'b0, 4, 0, 1'b0);

        // Counter wrap: 2^CNT_W deliveries since reset returns to 0
        for (int i = 1; i < (1 << CNT_W); i++) run(32'h0, 3, 1'b0, 4, 0, 1'b0);
        check("count_wrapped", sample_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
